ysyx_22040088_lsu: RTL and testbench

- Load/store unit directly upstream of the writeback-data generator.
- Accepts one memory op from execute, runs one request/response transaction on the data bus, and aligns load data down to bit 0.
- Presents rdata plus a one-hot size mask to the writeback stage, which performs the sign or zero extension.
- Single outstanding op; blocking.

---
 rtl/ysyx_22040088_lsu.sv | 172 +++++++++++++++++
 tb/tb_ysyx_22040088_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: runs one blocking memory op per bus req/resp transaction and
// hands right-aligned load data plus a one-hot size mask to writeback.
module ysyx_22040088_lsu #(
  parameter int         ADDR_W  = 64,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [63:0]       in_wdata,
  input  logic [1:0]        in_size,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_wen,
  output logic [63:0]       bus_req_wdata,
  output logic [7:0]        bus_req_wstrb,
  input  logic              bus_resp_valid,
  input  logic [63:0]       bus_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_rdata,
  output logic [3:0]        out_mask,
  output logic              out_misalign,
  output logic              out_err
);

  // state | meaning
  // IDLE  | waiting for an op from execute, in_ready high
  // REQ   | bus request presented, held until bus_req_ready
  // WAIT  | request accepted, waiting for response or timeout
  // RESP  | result presented to writeback, held until out_ready
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] off;
  logic [1:0] size;
  logic       is_load;

  logic       op_load;
  logic       op_store;
  logic       op_misalign;
  logic [7:0] size_ones;

  function automatic logic [3:0] mask_of(input logic [1:0] sz);
    case (sz)
      2'd0:    mask_of = 4'b1000;
      2'd1:    mask_of = 4'b0100;
      2'd2:    mask_of = 4'b0010;
      default: mask_of = 4'b0001;
    endcase
  endfunction

  // A simultaneous load+store request is treated as a load.
  assign op_load  = in_load;
  assign op_store = in_store & ~in_load;

  always_comb begin
    op_misalign = 1'b0;
    size_ones   = 8'h01;
    case (in_size)
      2'd0: begin
        op_misalign = 1'b0;
        size_ones   = 8'h01;
      end
      2'd1: begin
        op_misalign = in_addr[0];
        size_ones   = 8'h03;
      end
      2'd2: begin
        op_misalign = |in_addr[1:0];
        size_ones   = 8'h0F;
      end
      default: begin
        op_misalign = |in_addr[2:0];
        size_ones   = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      off           <= 3'd0;
      size          <= 2'd0;
      is_load       <= 1'b0;
      in_ready      <= 1'b1;
      bus_req_valid <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wen   <= 1'b0;
      bus_req_wdata <= 64'd0;
      bus_req_wstrb <= 8'd0;
      out_valid     <= 1'b0;
      out_rdata     <= 64'd0;
      out_mask      <= 4'd0;
      out_misalign  <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            off      <= in_addr[2:0];
            size     <= in_size;
            is_load  <= op_load;
            if (op_misalign) begin
              state        <= RESP;
              out_valid    <= 1'b1;
              out_misalign <= 1'b1;
              out_mask     <= op_load ? mask_of(in_size) : 4'd0;
            end else if (!(op_load || op_store)) begin
              state     <= RESP;
              out_valid <= 1'b1;
            end else begin
              state         <= REQ;
              bus_req_valid <= 1'b1;
              bus_req_addr  <= {in_addr[ADDR_W-1:3], 3'b000};
              bus_req_wen   <= op_store;
              bus_req_wdata <= in_wdata << {in_addr[2:0], 3'b000};
              bus_req_wstrb <= op_store ? (size_ones << in_addr[2:0]) : 8'd0;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            state         <= WAIT;
            cnt           <= 8'd0;
            bus_req_valid <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wen   <= 1'b0;
            bus_req_wdata <= 64'd0;
            bus_req_wstrb <= 8'd0;
          end
        end
        WAIT: begin
          // A response on the final timeout cycle still counts as a response.
          if (bus_resp_valid) begin
            state     <= RESP;
            out_valid <= 1'b1;
            out_rdata <= is_load ? (bus_resp_rdata >> {off, 3'b000}) : 64'd0;
            out_mask  <= is_load ? mask_of(size) : 4'd0;
          end else if (cnt == TIMEOUT - 8'd1) begin
            state     <= RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (out_ready) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_rdata    <= 64'd0;
            out_mask     <= 4'd0;
            out_misalign <= 1'b0;
            out_err      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Bench for ysyx_22040088_lsu: directed scenarios plus randomized ops compared
// against an arithmetic reference of the expected bus and writeback values.
module tb_ysyx_22040088_lsu;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_load, in_store;
  logic [63:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        bus_req_valid, bus_req_ready, bus_req_wen;
  logic [63:0] bus_req_addr, bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_rdata;
  logic        out_valid, out_ready, out_misalign, out_err;
  logic [63:0] out_rdata;
  logic [3:0]  out_mask;

  int n_vec = 0;
  int n_err = 0;

  ysyx_22040088_lsu #(.ADDR_W(64), .TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_mask(out_mask), .out_misalign(out_misalign), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input bit full);
    chk({tag, ".in_ready"},  64'(in_ready), 64'd1);
    chk({tag, ".req_valid"}, 64'(bus_req_valid), 64'd0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_rdata"}, out_rdata, 64'd0);
    chk({tag, ".out_mask"},  64'(out_mask), 64'd0);
    chk({tag, ".misalign"},  64'(out_misalign), 64'd0);
    chk({tag, ".err"},       64'(out_err), 64'd0);
    if (full) begin
      chk({tag, ".req_addr"},  bus_req_addr, 64'd0);
      chk({tag, ".req_wen"},   64'(bus_req_wen), 64'd0);
      chk({tag, ".req_wdata"}, bus_req_wdata, 64'd0);
      chk({tag, ".req_wstrb"}, 64'(bus_req_wstrb), 64'd0);
    end
  endtask

  task automatic scramble_inputs();
    in_load  = 1'($urandom);
    in_store = 1'($urandom);
    in_addr  = {$urandom, $urandom};
    in_wdata = {$urandom, $urandom};
    in_size  = 2'($urandom);
  endtask

  task automatic drive_accept(input bit ld_f, input bit st_f, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [1:0] size);
    chk("accept.in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_load  = ld_f;
    in_store = st_f;
    in_addr  = addr;
    in_wdata = wdata;
    in_size  = size;
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // resp_k: WAIT cycle (1-based) carrying the response; outside 1..T means none.
  task automatic run_op(input bit ld_f, input bit st_f, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [1:0] size,
                        input int rdy_dly, input int resp_k, input logic [63:0] rdata,
                        input int ord_dly, input bit spur);
    bit          is_ld, is_st, mis, got;
    int          nbytes, off, n;
    logic [3:0]  szm, e_mask;
    logic [15:0] s;
    logic [7:0]  e_strb;
    logic [63:0] e_wd, e_rd;
    bit          e_mis, e_err;

    is_ld  = ld_f;
    is_st  = st_f && !ld_f;
    nbytes = 1 << size;
    off    = int'(addr % 64'd8);
    mis    = (addr % 64'(nbytes)) != 64'd0;
    szm    = 4'(8 >> size);
    s      = ((16'd1 << nbytes) - 16'd1) << off;
    e_strb = is_st ? s[7:0] : 8'd0;
    e_wd   = wdata << (8 * off);

    drive_accept(ld_f, st_f, addr, wdata, size);

    if (mis || !(is_ld || is_st)) begin
      chk("short.req_valid", 64'(bus_req_valid), 64'd0);
      e_rd   = 64'd0;
      e_mask = (mis && is_ld) ? szm : 4'd0;
      e_mis  = mis;
      e_err  = 1'b0;
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk("req.out_valid", 64'(out_valid), 64'd0);
        chk("req.in_ready",  64'(in_ready), 64'd0);
        chk("req.valid",     64'(bus_req_valid), 64'd1);
        chk("req.addr",      bus_req_addr, addr & ~64'h7);
        chk("req.wen",       64'(bus_req_wen), 64'(is_st));
        chk("req.wdata",     bus_req_wdata, e_wd);
        chk("req.wstrb",     64'(bus_req_wstrb), 64'(e_strb));
        bus_resp_valid = spur;
        bus_resp_rdata = {$urandom, $urandom};
        bus_req_ready  = (i == rdy_dly);
        @(negedge clk);
      end
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      got = (resp_k >= 1) && (resp_k <= T);
      n   = got ? resp_k : T;
      for (int w = 1; w <= n; w++) begin
        chk("wait.out_valid", 64'(out_valid), 64'd0);
        chk("wait.req_valid", 64'(bus_req_valid), 64'd0);
        if (w == resp_k) begin
          bus_resp_valid = 1'b1;
          bus_resp_rdata = rdata;
        end
        @(negedge clk);
        bus_resp_valid = 1'b0;
      end
      e_err  = !got;
      e_rd   = (got && is_ld) ? (rdata >> (8 * off)) : 64'd0;
      e_mask = (got && is_ld) ? szm : 4'd0;
      e_mis  = 1'b0;
    end

    for (int j = 0; j <= ord_dly; j++) begin
      chk("resp.out_valid", 64'(out_valid), 64'd1);
      chk("resp.in_ready",  64'(in_ready), 64'd0);
      chk("resp.req_valid", 64'(bus_req_valid), 64'd0);
      chk("resp.rdata",     out_rdata, e_rd);
      chk("resp.mask",      64'(out_mask), 64'(e_mask));
      chk("resp.misalign",  64'(out_misalign), 64'(e_mis));
      chk("resp.err",       64'(out_err), 64'(e_err));
      out_ready = (j == ord_dly);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk_idle("done", 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    in_addr = 64'd0; in_wdata = 64'd0; in_size = 2'd0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = 64'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset", 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // lw, immediate bus, response next cycle: out_valid in the third cycle
    run_op(1, 0, 64'h8000_0004, {$urandom, $urandom}, 2'd2, 0, 1,
           64'hAABBCCDD_11223344, 0, 0);
    // sb to byte 3
    run_op(0, 1, 64'h8000_0003, 64'h5A, 2'd0, 0, 1, {$urandom, $urandom}, 0, 0);
    // misaligned lh, writeback stalls 3 cycles
    run_op(1, 0, 64'h8000_0001, 64'd0, 2'd1, 0, 1, 64'd0, 3, 0);
    // ld with bus stall then timeout; late response in IDLE is ignored
    run_op(1, 0, 64'h8000_0008, 64'd0, 2'd3, 5, 0, 64'd0, 0, 1);
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 64'hDEAD_BEEF_0000_1111;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    chk_idle("late_resp", 1'b0);
    @(negedge clk);
    chk_idle("late_resp2", 1'b0);
    // non-memory op
    run_op(0, 0, 64'h8000_0010, 64'd0, 2'd3, 0, 1, 64'd0, 1, 0);
    // load+store both set behaves as a load
    run_op(1, 1, 64'h8000_0002, 64'hFFFF, 2'd1, 1, 2, 64'h0123_4567_89AB_CDEF, 0, 0);
    // response on the last timeout cycle wins
    run_op(1, 0, 64'h8000_0020, 64'd0, 2'd3, 0, T, 64'h1122_3344_5566_7788, 0, 0);

    // reset while in WAIT
    drive_accept(1, 0, 64'h8000_0040, 64'd0, 2'd3);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("rstwait.out_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_wait", 1'b1);
    run_op(1, 0, 64'h8000_0007, 64'd0, 2'd0, 0, 1,
           {8'hF0, 24'($urandom), $urandom}, 0, 0);

    for (int k = 0; k < 80; k++) begin
      logic [63:0] a;
      a = {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom};
      run_op(1'($urandom), 1'($urandom), a, {$urandom, $urandom}, 2'($urandom),
             $urandom_range(0, 3), $urandom_range(0, T + 1), {$urandom, $urandom},
             $urandom_range(0, 2), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
